demux1_4: RTL and testbench

DEMUX1_4 -- requirements
Module: demux1_4

---
 rtl/demux_pkg.sv | 23 ++
 rtl/demux1_4_chk.sv | 21 ++
 rtl/demux_lane.sv | 75 +++++++
 rtl/demux1_4.sv | 106 ++++++++++
 tb/tb_demux1_4.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the 1:4 demux and its companion 4:1 mux:
// default lane width, lane index type and the sel-to-lane mapping.
package demux_pkg;

  localparam int unsigned DEMUX_WIDTH_DEFAULT = 2;
  localparam int          NUM_LANES           = 4;

  typedef logic [1:0] lane_idx_t;

  // Reversed mapping so that demux and mux form a loopback pair
  function automatic lane_idx_t sel_to_lane(input logic [1:0] sel);
    lane_idx_t lane;
    case (sel)
      2'b00:   lane = 2'd3;
      2'b01:   lane = 2'd2;
      2'b10:   lane = 2'd1;
      2'b11:   lane = 2'd0;
      default: lane = 2'd0;
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/demux1_4_chk.sv
// Protocol checker for demux1_4: stall stability and reset gating of din_rdy.
module demux1_4_chk #(
  parameter int unsigned WIDTH = 2
) (
  input logic               clk,
  input logic               rst,
  input logic               din_rdy,
  input logic [3:0]         vld,
  input logic [3:0]         rdy,
  input logic [4*WIDTH-1:0] data
);

  a_rdy_in_reset: assert property (@(posedge clk) rst |-> !din_rdy);

  // A stalled full slot must keep both its valid and its data
  for (genvar n = 0; n < 4; n++) begin : g_chk
    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
      (vld[n] && !rdy[n]) |=> (vld[n] && $stable(data[n*WIDTH +: WIDTH])));
  end

endmodule

// File: rtl/demux_lane.sv
// One output slot of the demux: data register, valid flag and, when
// DEMUX1_4_CNT_EN is defined, an 8-bit completed-handshake counter.
module demux_lane
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             rdy_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             vld_o,
  output logic             free_o
`ifdef DEMUX1_4_CNT_EN
  ,
  output logic [7:0]       cnt_o
`endif
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             vld_q;
  logic             vld_d;
  logic             hs_s;

  assign hs_s   = vld_q & rdy_i;
  assign free_o = ~vld_q | rdy_i;
  assign dout_o = data_q;
  assign vld_o  = vld_q;

  // Slot next state: a load wins over a simultaneous drain
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (load_i) begin
      data_d = din_i;
      vld_d  = 1'b1;
    end else if (hs_s) begin
      vld_d  = 1'b0;
    end else begin
      vld_d  = vld_q;
    end
  end

  // Slot registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= {WIDTH{1'b0}};
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

`ifdef DEMUX1_4_CNT_EN
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign cnt_d = hs_s ? (cnt_q + 8'd1) : cnt_q;
  assign cnt_o = cnt_q;

  // Handshake counter, wraps naturally at 8 bits
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

endmodule

// File: rtl/demux1_4.sv
// 1:4 valid/ready demultiplexer with a one-entry slot per lane.
// Define DEMUX1_4_CNT_EN to add per-lane handshake counters cnt0..cnt3.
module demux1_4
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_vld,
  input  logic [1:0]       sel,
  output logic             din_rdy,
  output logic [WIDTH-1:0] d0,
  output logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] d3,
  output logic             d0_vld,
  output logic             d1_vld,
  output logic             d2_vld,
  output logic             d3_vld,
  input  logic             d0_rdy,
  input  logic             d1_rdy,
  input  logic             d2_rdy,
  input  logic             d3_rdy
`ifdef DEMUX1_4_CNT_EN
  ,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1,
  output logic [7:0]       cnt2,
  output logic [7:0]       cnt3
`endif
);

  lane_idx_t        tgt_s;
  logic             accept_s;
  logic [3:0]       load_s;
  logic [3:0]       free_s;
  logic [3:0]       vld_s;
  logic [3:0]       rdy_s;
  logic [WIDTH-1:0] data_s [NUM_LANES];

  assign rdy_s    = {d3_rdy, d2_rdy, d1_rdy, d0_rdy};
  assign tgt_s    = sel_to_lane(sel);
  // Ready looks only at the target slot, never at din_vld
  assign din_rdy  = ~rst & free_s[tgt_s];
  assign accept_s = din_vld & din_rdy;

  // Steer the accept to exactly one lane
  always_comb begin
    load_s = 4'b0000;
    if (accept_s) begin
      load_s[tgt_s] = 1'b1;
    end else begin
      load_s = 4'b0000;
    end
  end

`ifdef DEMUX1_4_CNT_EN
  logic [7:0] cnt_s [NUM_LANES];
  assign cnt0 = cnt_s[0];
  assign cnt1 = cnt_s[1];
  assign cnt2 = cnt_s[2];
  assign cnt3 = cnt_s[3];
`endif

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    demux_lane #(
      .WIDTH (WIDTH)
    ) u_lane (
      .clk_i  (clk),
      .rst_i  (rst),
      .load_i (load_s[n]),
      .din_i  (din),
      .rdy_i  (rdy_s[n]),
      .dout_o (data_s[n]),
      .vld_o  (vld_s[n]),
      .free_o (free_s[n])
`ifdef DEMUX1_4_CNT_EN
      ,
      .cnt_o  (cnt_s[n])
`endif
    );
  end

  assign d0     = data_s[0];
  assign d1     = data_s[1];
  assign d2     = data_s[2];
  assign d3     = data_s[3];
  assign d0_vld = vld_s[0];
  assign d1_vld = vld_s[1];
  assign d2_vld = vld_s[2];
  assign d3_vld = vld_s[3];

  demux1_4_chk #(
    .WIDTH (WIDTH)
  ) u_chk (
    .clk     (clk),
    .rst     (rst),
    .din_rdy (din_rdy),
    .vld     (vld_s),
    .rdy     (rdy_s),
    .data    ({data_s[3], data_s[2], data_s[1], data_s[0]})
  );

endmodule

// File: tb/tb_demux1_4.sv
// Bench for demux1_4: directed vector table, hand sequences and a random
// run against a lane-slot reference model (counters when DEMUX1_4_CNT_EN).
module tb_demux1_4;

  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_vld;
  logic [1:0]   sel;
  logic         din_rdy;
  logic [W-1:0] d0, d1, d2, d3;
  logic         d0_vld, d1_vld, d2_vld, d3_vld;
  logic         d0_rdy, d1_rdy, d2_rdy, d3_rdy;
`ifdef DEMUX1_4_CNT_EN
  logic [7:0]   cnt0, cnt1, cnt2, cnt3;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  demux1_4 #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .din_vld (din_vld),
    .sel     (sel),
    .din_rdy (din_rdy),
    .d0      (d0),
    .d1      (d1),
    .d2      (d2),
    .d3      (d3),
    .d0_vld  (d0_vld),
    .d1_vld  (d1_vld),
    .d2_vld  (d2_vld),
    .d3_vld  (d3_vld),
    .d0_rdy  (d0_rdy),
    .d1_rdy  (d1_rdy),
    .d2_rdy  (d2_rdy),
    .d3_rdy  (d3_rdy)
`ifdef DEMUX1_4_CNT_EN
    ,
    .cnt0    (cnt0),
    .cnt1    (cnt1),
    .cnt2    (cnt2),
    .cnt3    (cnt3)
`endif
  );

  // Reference model: one slot per lane, lane number = 3 - sel
  bit           m_full [4];
  logic [W-1:0] m_data [4];
  logic [7:0]   m_cnt  [4];

  typedef struct {
    logic         rst;
    logic         vld;
    logic [1:0]   sel;
    logic [W-1:0] din;
    logic [3:0]   rdy;     // {d3,d2,d1,d0}
    logic         e_rdy;   // din_rdy before the edge
    logic [3:0]   e_vld;   // {d3..d0}_vld after the edge
    logic [4*W-1:0] e_data; // {d3,d2,d1,d0} after the edge
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(input logic r, input logic v, input logic [1:0] s,
                              input logic [W-1:0] di, input logic [3:0] rd,
                              input logic er, input logic [3:0] ev,
                              input logic [4*W-1:0] ed);
    vec_t t;
    t.rst = r; t.vld = v; t.sel = s; t.din = di; t.rdy = rd;
    t.e_rdy = er; t.e_vld = ev; t.e_data = ed;
    return t;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 4; n++) begin
      m_full[n] = 1'b0;
      m_data[n] = '0;
      m_cnt[n]  = 8'd0;
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [1:0] s,
                      input logic [W-1:0] di, input logic [3:0] rd,
                      input bit use_tbl, input logic e_rdy,
                      input logic [3:0] e_vld, input logic [4*W-1:0] e_data);
    int             ln;
    bit             acc;
    bit             hs [4];
    logic           x_rdy;
    logic [3:0]     x_vld;
    logic [4*W-1:0] x_data;
    @(negedge clk);
    rst = r; din_vld = v; sel = s; din = di;
    {d3_rdy, d2_rdy, d1_rdy, d0_rdy} = rd;
    #1;
    ln    = 3 - int'(s);
    x_rdy = use_tbl ? e_rdy : logic'(!r && (!m_full[ln] || rd[ln]));
    vectors++;
    if (din_rdy !== x_rdy) begin
      miscompares++;
      $display("FAIL din_rdy @%0t: got %b expected %b", $time, din_rdy, x_rdy);
    end
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      acc = v && (!m_full[ln] || rd[ln]);
      for (int n = 0; n < 4; n++) begin
        hs[n] = m_full[n] && rd[n];
        if (hs[n]) m_cnt[n] = m_cnt[n] + 8'd1;
        if (acc && n == ln) begin
          m_data[n] = di;
          m_full[n] = 1'b1;
        end else if (hs[n]) begin
          m_full[n] = 1'b0;
        end
      end
    end
    #1;
    if (use_tbl) begin
      x_vld  = e_vld;
      x_data = e_data;
    end else begin
      x_vld  = {m_full[3], m_full[2], m_full[1], m_full[0]};
      x_data = {m_data[3], m_data[2], m_data[1], m_data[0]};
    end
    vectors++;
    if ({d3_vld, d2_vld, d1_vld, d0_vld} !== x_vld || {d3, d2, d1, d0} !== x_data) begin
      miscompares++;
      $display("FAIL lanes @%0t: got vld=%b data=%b expected vld=%b data=%b", $time,
               {d3_vld, d2_vld, d1_vld, d0_vld}, {d3, d2, d1, d0}, x_vld, x_data);
    end
`ifdef DEMUX1_4_CNT_EN
    vectors++;
    if ({cnt3, cnt2, cnt1, cnt0} !== {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]}) begin
      miscompares++;
      $display("FAIL counters @%0t: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d", $time,
               cnt3, cnt2, cnt1, cnt0, m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]);
    end
`endif
  endtask

  initial begin
    rst = 1'b1; din_vld = 1'b0; sel = 2'b00; din = '0;
    {d3_rdy, d2_rdy, d1_rdy, d0_rdy} = 4'b0000;
    model_reset();

    //            rst   vld   sel    din    rdy      e_rdy e_vld    e_data {d3,d2,d1,d0}
    tbl[0]  = mk(1'b1, 1'b1, 2'b00, 2'b11, 4'b1111, 1'b0, 4'b0000, 8'b00_00_00_00);
    tbl[1]  = mk(1'b1, 1'b1, 2'b00, 2'b11, 4'b1111, 1'b0, 4'b0000, 8'b00_00_00_00);
    tbl[2]  = mk(1'b0, 1'b0, 2'b00, 2'b00, 4'b1111, 1'b1, 4'b0000, 8'b00_00_00_00);
    tbl[3]  = mk(1'b0, 1'b1, 2'b00, 2'b01, 4'b1111, 1'b1, 4'b1000, 8'b01_00_00_00);
    tbl[4]  = mk(1'b0, 1'b1, 2'b01, 2'b01, 4'b1111, 1'b1, 4'b0100, 8'b01_01_00_00);
    tbl[5]  = mk(1'b0, 1'b1, 2'b10, 2'b01, 4'b1111, 1'b1, 4'b0010, 8'b01_01_01_00);
    tbl[6]  = mk(1'b0, 1'b1, 2'b11, 2'b01, 4'b1111, 1'b1, 4'b0001, 8'b01_01_01_01);
    tbl[7]  = mk(1'b0, 1'b0, 2'b00, 2'b00, 4'b1111, 1'b1, 4'b0000, 8'b01_01_01_01);
    tbl[8]  = mk(1'b0, 1'b1, 2'b00, 2'b10, 4'b0111, 1'b1, 4'b1000, 8'b10_01_01_01);
    tbl[9]  = mk(1'b0, 1'b1, 2'b00, 2'b11, 4'b0111, 1'b0, 4'b1000, 8'b10_01_01_01);
    tbl[10] = mk(1'b0, 1'b1, 2'b00, 2'b11, 4'b1111, 1'b1, 4'b1000, 8'b11_01_01_01);
    tbl[11] = mk(1'b0, 1'b1, 2'b11, 2'b10, 4'b0111, 1'b1, 4'b1001, 8'b11_01_01_10);
    tbl[12] = mk(1'b0, 1'b0, 2'b00, 2'b00, 4'b0111, 1'b0, 4'b1000, 8'b11_01_01_10);
    tbl[13] = mk(1'b0, 1'b1, 2'b01, 2'b11, 4'b0000, 1'b1, 4'b1100, 8'b11_11_01_10);
    tbl[14] = mk(1'b0, 1'b1, 2'b10, 2'b10, 4'b0000, 1'b1, 4'b1110, 8'b11_11_10_10);
    tbl[15] = mk(1'b0, 1'b1, 2'b11, 2'b11, 4'b0000, 1'b1, 4'b1111, 8'b11_11_10_11);
    tbl[16] = mk(1'b0, 1'b1, 2'b00, 2'b00, 4'b0000, 1'b0, 4'b1111, 8'b11_11_10_11);
    tbl[17] = mk(1'b1, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 4'b0000, 8'b00_00_00_00);
    tbl[18] = mk(1'b0, 1'b1, 2'b10, 2'b11, 4'b0000, 1'b1, 4'b0010, 8'b00_00_11_00);

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].rst, tbl[i].vld, tbl[i].sel, tbl[i].din, tbl[i].rdy,
           1'b1, tbl[i].e_rdy, tbl[i].e_vld, tbl[i].e_data);
    end

`ifdef DEMUX1_4_CNT_EN
    // 257 back-to-back handshakes on lane 1, then drain the last beat
    step(1'b1, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 4'b0000, '0);
    for (int i = 0; i < 257; i++) begin
      step(1'b0, 1'b1, 2'b10, W'($urandom), 4'b1111, 1'b0, 1'b0, 4'b0000, '0);
    end
    step(1'b0, 1'b0, 2'b00, 2'b00, 4'b1111, 1'b0, 1'b0, 4'b0000, '0);
    vectors++;
    if (cnt1 !== 8'd1 || cnt0 !== 8'd0 || cnt2 !== 8'd0 || cnt3 !== 8'd0) begin
      miscompares++;
      $display("FAIL cnt_wrap: got %0d/%0d/%0d/%0d expected 0/0/1/0", cnt3, cnt2, cnt1, cnt0);
    end
`endif

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(logic'($urandom_range(31) == 0), logic'($urandom), 2'($urandom),
           W'($urandom), 4'($urandom), 1'b0, 1'b0, 4'b0000, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
